// File: rtl/cordic_pkg.sv
// Shared constants for the rotation-mode CORDIC pipeline.
//   DATA_WIDTH / FRACTIONAL_WIDTH : Q2.20 word format
//   SHIFT_WIDTH                   : width of the per-stage iteration index
//   CORDIC_K                      : initial x (gain compensation, 0.607253)
//   atan_entry(i)                 : atan(2^-i) in Q2.20, truncated toward zero
package cordic_pkg;

  localparam int DATA_WIDTH       = 22;
  localparam int FRACTIONAL_WIDTH = 20;
  localparam int SHIFT_WIDTH      = 4;
  localparam int NUM_STAGES       = 16;

  localparam logic [DATA_WIDTH-1:0] CORDIC_K = 22'h09B74E;

  function automatic logic [DATA_WIDTH-1:0] atan_entry(input logic [SHIFT_WIDTH-1:0] i);
    logic [DATA_WIDTH-1:0] a;
    a = '0;
    case (i)
      4'd0:  a = 22'h0C90FD;
      4'd1:  a = 22'h076B19;
      4'd2:  a = 22'h03EB6E;
      4'd3:  a = 22'h01FD5B;
      4'd4:  a = 22'h00FFAA;
      4'd5:  a = 22'h007FF5;
      4'd6:  a = 22'h003FFE;
      4'd7:  a = 22'h001FFF;
      4'd8:  a = 22'h000FFF;
      4'd9:  a = 22'h0007FF;
      4'd10: a = 22'h0003FF;
      4'd11: a = 22'h0001FF;
      4'd12: a = 22'h0000FF;
      4'd13: a = 22'h00007F;
      4'd14: a = 22'h00003F;
      4'd15: a = 22'h00001F;
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered micro-rotation of a rotation-mode CORDIC.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all outputs)
//   clk_en              update enable for every output register
//   target, valid_in    target angle and sample tag, forwarded one cycle later
//   shift_value         iteration index i (shift amount)
//   shift_angle         atan(2^-i) for this stage
//   angle, x, y         current rotation state z_i, x_i, y_i
//   new_angle/x/y       registered z_{i+1}, x_{i+1}, y_{i+1}
//   target_out          registered target
//   valid_out           registered valid_in
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH       = cordic_pkg::DATA_WIDTH,
  parameter int FRACTIONAL_WIDTH = cordic_pkg::FRACTIONAL_WIDTH,
  parameter int SHIFT_WIDTH      = cordic_pkg::SHIFT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic                  valid_in,
  input  logic [SHIFT_WIDTH-1:0] shift_value,
  input  logic [DATA_WIDTH-1:0] shift_angle,
  input  logic [DATA_WIDTH-1:0] angle,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [DATA_WIDTH-1:0] new_angle,
  output logic [DATA_WIDTH-1:0] new_x,
  output logic [DATA_WIDTH-1:0] new_y,
  output logic [DATA_WIDTH-1:0] target_out,
  output logic                  valid_out
);

  // The fraction position only matters to whoever interprets the words;
  // it must at least leave room for a sign bit.
  if (FRACTIONAL_WIDTH >= DATA_WIDTH) begin : g_fmt_check
    $error("cordic_stage: FRACTIONAL_WIDTH must be below DATA_WIDTH");
  end

  logic                  dir_pos;  // d = +1: rotate counter-clockwise
  logic [DATA_WIDTH-1:0] x_sh;
  logic [DATA_WIDTH-1:0] y_sh;

  // Arithmetic shift floors toward -inf, which is the intended truncation.
  assign x_sh    = DATA_WIDTH'($signed(x) >>> shift_value);
  assign y_sh    = DATA_WIDTH'($signed(y) >>> shift_value);
  // Tie (target == angle) rotates positive.
  assign dir_pos = $signed(target) >= $signed(angle);

  // valid never gates the datapath; it just rides along with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_x      <= '0;
      new_y      <= '0;
      new_angle  <= '0;
      target_out <= '0;
      valid_out  <= 1'b0;
    end else if (clk_en) begin
      new_x      <= dir_pos ? (x - y_sh) : (x + y_sh);
      new_y      <= dir_pos ? (y + x_sh) : (y - x_sh);
      new_angle  <= dir_pos ? (angle + shift_angle) : (angle - shift_angle);
      target_out <= target;
      valid_out  <= valid_in;
    end
  end

endmodule

// File: tb/tb_cordic_stage.sv
module tb_cordic_stage;
  import cordic_pkg::*;

  localparam int DW = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic [DW-1:0] target = '0;
  logic          valid_in = 1'b0;
  logic [3:0]    shift_value = '0;
  logic [DW-1:0] shift_angle = '0;
  logic [DW-1:0] angle = '0;
  logic [DW-1:0] x = '0;
  logic [DW-1:0] y = '0;
  logic [DW-1:0] new_angle, new_x, new_y, target_out;
  logic          valid_out;

  int checks = 0;
  int errors = 0;

  cordic_stage dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .target(target),
    .valid_in(valid_in), .shift_value(shift_value), .shift_angle(shift_angle),
    .angle(angle), .x(x), .y(y), .new_angle(new_angle), .new_x(new_x),
    .new_y(new_y), .target_out(target_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: plain integer arithmetic ----------------
  function automatic longint sval(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // floor(v / 2^s)
  function automatic longint fdiv(input longint v, input int s);
    longint p, q;
    p = longint'(1) << s;
    q = v / p;
    if (v < 0 && (v % p) != 0) q = q - 1;
    return q;
  endfunction

  logic [DW-1:0] m_x = '0, m_y = '0, m_a = '0, m_t = '0;
  logic          m_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    longint vx, vy, va, vt, d;
    if (!rst_n) begin
      m_x <= '0; m_y <= '0; m_a <= '0; m_t <= '0; m_v <= 1'b0;
    end else if (clk_en) begin
      vx = sval(x); vy = sval(y); va = sval(angle); vt = sval(target);
      d  = (vt >= va) ? 1 : -1;
      m_x <= DW'(vx - d * fdiv(vy, int'(shift_value)));
      m_y <= DW'(vy + d * fdiv(vx, int'(shift_value)));
      m_a <= DW'(va + d * sval(shift_angle));
      m_t <= target;
      m_v <= valid_in;
    end
  end

  // Outputs are meaningful every cycle; compare on the falling edge.
  always @(negedge clk) begin
    chk("model_x", new_x, m_x);
    chk("model_y", new_y, m_y);
    chk("model_angle", new_angle, m_a);
    chk("model_target", target_out, m_t);
    chk("model_valid", DW'(valid_out), DW'(m_v));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] i, input logic [DW-1:0] sa, input logic [DW-1:0] xi,
                       input logic [DW-1:0] yi, input logic [DW-1:0] ai,
                       input logic [DW-1:0] ti, input logic vi);
    shift_value = i; shift_angle = sa; x = xi; y = yi; angle = ai; target = ti; valid_in = vi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_x", new_x, '0);
    chk("rst_valid", DW'(valid_out), '0);
    rst_n = 1'b1;

    // 1: i=0, positive target
    drive(4'd0, atan_entry(4'd0), CORDIC_K, '0, '0, 22'h080000, 1'b1);
    tick();
    chk("t1_x", new_x, 22'h09B74E);
    chk("t1_y", new_y, 22'h09B74E);
    chk("t1_angle", new_angle, 22'h0C90FD);
    chk("t1_valid", DW'(valid_out), 22'h1);

    // 2: negative target -> d = -1
    target = 22'h380000;
    tick();
    chk("t2_x", new_x, 22'h09B74E);
    chk("t2_y", new_y, 22'h3648B2);
    chk("t2_angle", new_angle, 22'h336F03);

    // 3: i=1
    drive(4'd1, atan_entry(4'd1), 22'h100000, 22'h080000, '0, 22'h100000, 1'b1);
    tick();
    chk("t3_x", new_x, 22'h0C0000);
    chk("t3_y", new_y, 22'h100000);
    chk("t3_angle", new_angle, 22'h076B19);
    chk("t3_target", target_out, 22'h100000);

    // 4: arithmetic shift of a negative y, tie case
    drive(4'd2, atan_entry(4'd2), '0, 22'h300000, '0, '0, 1'b1);
    tick();
    chk("t4_x", new_x, 22'h040000);
    chk("t4_y", new_y, 22'h300000);
    chk("t4_angle", new_angle, 22'h03EB6E);

    // 5: clk_en low for 3 cycles while inputs change
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(4'd0, atan_entry(4'd0), CORDIC_K, '0, '0, 22'h080000, k[0]);
      tick();
      chk("t5_hold_x", new_x, 22'h040000);
      chk("t5_hold_y", new_y, 22'h300000);
      chk("t5_hold_target", target_out, '0);
      chk("t5_hold_valid", DW'(valid_out), 22'h1);
    end
    valid_in = 1'b1;
    clk_en = 1'b1;
    tick();
    chk("t5_resume_x", new_x, 22'h09B74E);
    chk("t5_resume_y", new_y, 22'h09B74E);
    chk("t5_resume_target", target_out, 22'h080000);

    // Wrap-around: max positive + max positive
    drive(4'd0, atan_entry(4'd0), 22'h1FFFFF, 22'h1FFFFF, '0, '0, 1'b0);
    tick();
    chk("wrap_y", new_y, 22'h3FFFFE);
    chk("wrap_x", new_x, '0);
    chk("wrap_valid", DW'(valid_out), '0);

    // i=15: small negative x floors to -1
    drive(4'd15, atan_entry(4'd15), 22'h3FFFFF, 22'h000010, 22'h000005, 22'h000004, 1'b1);
    tick();
    chk("i15_y", new_y, 22'h000011);
    chk("i15_x", new_x, 22'h3FFFFF);
    chk("i15_angle", new_angle, 22'h3FFFE6);

    // Random vectors, checked by the model
    for (int k = 0; k < 200; k++) begin
      drive(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), DW'($urandom),
            DW'($urandom), (k % 7 == 0) ? angle : DW'($urandom), 1'($urandom));
      if (k % 7 == 0) target = angle;
      clk_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    clk_en = 1'b1;

    // 6: async reset between edges with valid_out high
    drive(4'd1, atan_entry(4'd1), 22'h100000, 22'h080000, '0, 22'h100000, 1'b1);
    tick();
    chk("t6_pre_valid", DW'(valid_out), 22'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_x", new_x, '0);
    chk("t6_async_target", target_out, '0);
    chk("t6_async_valid", DW'(valid_out), '0);
    tick();
    tick();
    chk("t6_held_y", new_y, '0);
    chk("t6_held_valid", DW'(valid_out), '0);
    #3;
    rst_n = 1'b1;
    #1;
    chk("t6_release_valid", DW'(valid_out), '0);
    chk("t6_release_angle", new_angle, '0);
    tick();
    chk("t6_after_x", new_x, 22'h0C0000);
    chk("t6_after_valid", DW'(valid_out), 22'h1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
